// File: rtl/multicycle_datapath.sv
// Multi-cycle KGP-RISC datapath: FETCH/DECODE/EXEC/MEM/WB with req/ready memory ports.
// Optional performance counters are enabled by defining MCDP_PERF_CNT_EN.
module multicycle_datapath #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      alu_op,
  input  logic [1:0]      alu_src,
  input  logic            br_link,
  input  logic            mem_to_reg,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            branch,
  input  logic            halt,
  output logic [4:0]      opcode,
  output logic [4:0]      funccode,
  output logic [3:0]      flags,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic [XLEN-1:0] pc,
  output logic            halted
`ifdef MCDP_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
`endif
);

  localparam int RIDX = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int SHW  = $clog2(XLEN);
  localparam logic [RIDX-1:0] LINKREG = RIDX'(NREGS - 1);

  typedef enum logic [2:0] {
    stFetch, stDecode, stExec, stMem, stWb, stHalt
  } stateT;

  stateT           state;
  logic [31:0]     ir;
  logic [XLEN-1:0] aReg, bReg, aluOut, mdr;
  logic [XLEN-1:0] regFile [NREGS];
  logic [2:0]      aluOpQ;
  logic [1:0]      aluSrcQ;
  logic            brLinkQ, memToRegQ, memReadQ, memWriteQ, regWriteQ, branchQ;

  logic [RIDX-1:0] rsIdx, rtIdx;
  logic [XLEN-1:0] immEx, shamtEx, bSel, aluRes, pcPlus4, pcBranch;
  logic            aluCarry, aluOvf;
  logic [XLEN:0]   sum;

  assign rsIdx      = ir[22 +: RIDX];
  assign rtIdx      = ir[17 +: RIDX];
  assign immEx      = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign shamtEx    = {{(XLEN-5){1'b0}}, ir[16:12]};
  assign opcode     = ir[31:27];
  assign funccode   = ir[4:0];
  assign imem_addr  = pc;
  assign dmem_addr  = aluOut;
  assign dmem_wdata = bReg;
  assign pcPlus4    = pc + XLEN'(4);
  assign pcBranch   = pc + immEx;

  always_comb begin
    case (aluSrcQ)
      2'b00:   bSel = bReg;
      2'b01:   bSel = immEx;
      2'b10:   bSel = shamtEx;
      default: bSel = '0;
    endcase
  end

  always_comb begin
    sum      = '0;
    aluRes   = '0;
    aluCarry = 1'b0;
    aluOvf   = 1'b0;
    case (aluOpQ)
      3'b000: begin
        sum      = {1'b0, aReg} + {1'b0, bSel};
        aluRes   = sum[XLEN-1:0];
        aluCarry = sum[XLEN];
        aluOvf   = (aReg[XLEN-1] == bSel[XLEN-1]) && (aluRes[XLEN-1] != aReg[XLEN-1]);
      end
      3'b001: begin
        // carry is the raw carry-out of A + ~B + 1, i.e. 1 when no borrow
        sum      = {1'b0, aReg} + {1'b0, ~bSel} + (XLEN+1)'(1);
        aluRes   = sum[XLEN-1:0];
        aluCarry = sum[XLEN];
        aluOvf   = (aReg[XLEN-1] != bSel[XLEN-1]) && (aluRes[XLEN-1] != aReg[XLEN-1]);
      end
      3'b010:  aluRes = aReg & bSel;
      3'b011:  aluRes = aReg | bSel;
      3'b100:  aluRes = aReg ^ bSel;
      3'b101:  aluRes = aReg << bSel[SHW-1:0];
      3'b110:  aluRes = aReg >> bSel[SHW-1:0];
      default: aluRes = $signed(aReg) >>> bSel[SHW-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= stFetch;
      pc        <= RESET_PC;
      ir        <= '0;
      aReg      <= '0;
      bReg      <= '0;
      aluOut    <= '0;
      mdr       <= '0;
      flags     <= '0;
      aluOpQ    <= '0;
      aluSrcQ   <= '0;
      brLinkQ   <= 1'b0;
      memToRegQ <= 1'b0;
      memReadQ  <= 1'b0;
      memWriteQ <= 1'b0;
      regWriteQ <= 1'b0;
      branchQ   <= 1'b0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      halted    <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regFile[RIDX'(i)] <= '0;
    end else begin
      case (state)
        stFetch: begin
          if (imem_req && imem_ready) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= stDecode;
          end else begin
            imem_req <= 1'b1;
          end
        end
        stDecode: begin
          aReg      <= regFile[rsIdx];
          bReg      <= regFile[rtIdx];
          aluOpQ    <= alu_op;
          aluSrcQ   <= alu_src;
          brLinkQ   <= br_link;
          memToRegQ <= mem_to_reg;
          memReadQ  <= mem_read;
          memWriteQ <= mem_write;
          regWriteQ <= reg_write;
          branchQ   <= branch;
          if (halt) begin
            halted <= 1'b1;
            state  <= stHalt;
          end else begin
            state <= stExec;
          end
        end
        stExec: begin
          aluOut <= aluRes;
          flags  <= {aluCarry, (aluRes == '0), aluRes[XLEN-1], aluOvf};
          if (memReadQ || memWriteQ) begin
            dmem_req <= 1'b1;
            dmem_we  <= memWriteQ;
            state    <= stMem;
          end else begin
            state <= stWb;
          end
        end
        stMem: begin
          if (dmem_ready) begin
            mdr      <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= stWb;
          end
        end
        stWb: begin
          if (brLinkQ)        regFile[LINKREG] <= pcPlus4;
          else if (regWriteQ) regFile[rsIdx]   <= memToRegQ ? mdr : aluOut;
          pc       <= branchQ ? pcBranch : pcPlus4;
          imem_req <= 1'b1;
          state    <= stFetch;
        end
        stHalt: ;
        default: state <= stFetch;
      endcase
    end
  end

`ifdef MCDP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != stHalt) cycle_cnt   <= cycle_cnt + XLEN'(1);
      if (state == stWb)   instret_cnt <= instret_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: stimulus queues expected memory
// handshakes (fetch addr/CPI/flags, data addr/we/wdata); a monitor checks them.
module tb_multicycle_datapath;
  localparam int XLEN = 32;

  localparam logic [4:0] OP_ADDI = 5'd1,  OP_ADD = 5'd2,  OP_SUB = 5'd3,  OP_AND = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5,  OP_XOR = 5'd6,  OP_SLL = 5'd7,  OP_SRL = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9,  OP_SW  = 5'd10, OP_LW  = 5'd11, OP_BR  = 5'd12;
  localparam logic [4:0] OP_BAL  = 5'd13, OP_HALT = 5'd14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] alu_op;
  logic [1:0] alu_src;
  logic br_link, mem_to_reg, mem_read, mem_write, reg_write, branch, halt;
  logic [4:0] opcode, funccode;
  logic [3:0] flags;
  logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
  logic [XLEN-1:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [31:0] imem_rdata;
`ifdef MCDP_PERF_CNT_EN
  logic [XLEN-1:0] cycle_cnt, instret_cnt;
`endif

  multicycle_datapath #(.XLEN(XLEN), .NREGS(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .alu_src(alu_src), .br_link(br_link),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .branch(branch), .halt(halt), .opcode(opcode),
    .funccode(funccode), .flags(flags), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .pc(pc), .halted(halted)
`ifdef MCDP_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench-side control unit: decodes the bench's own opcode assignment.
  always_comb begin
    alu_op = 3'b000; alu_src = 2'b00; br_link = 1'b0; mem_to_reg = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; branch = 1'b0; halt = 1'b0;
    case (opcode)
      OP_ADDI: begin alu_src = 2'b01; reg_write = 1'b1; end
      OP_ADD:  reg_write = 1'b1;
      OP_SUB:  begin alu_op = 3'b001; reg_write = 1'b1; end
      OP_AND:  begin alu_op = 3'b010; reg_write = 1'b1; end
      OP_OR:   begin alu_op = 3'b011; reg_write = 1'b1; end
      OP_XOR:  begin alu_op = 3'b100; reg_write = 1'b1; end
      OP_SLL:  begin alu_op = 3'b101; alu_src = 2'b10; reg_write = 1'b1; end
      OP_SRL:  begin alu_op = 3'b110; alu_src = 2'b10; reg_write = 1'b1; end
      OP_SRA:  begin alu_op = 3'b111; alu_src = 2'b10; reg_write = 1'b1; end
      OP_SW:   begin alu_src = 2'b01; mem_write = 1'b1; end
      OP_LW:   begin alu_src = 2'b01; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_BR:   begin alu_src = 2'b11; branch = 1'b1; end
      OP_BAL:  begin alu_src = 2'b11; branch = 1'b1; br_link = 1'b1; reg_write = 1'b1; end
      OP_HALT: begin halt = 1'b1; branch = 1'b1; end
      default: ;
    endcase
  end

  typedef struct {
    bit          isData;
    logic [31:0] addr;
    bit          we;
    logic [31:0] data;
    int          gap;
    logic [3:0]  flg;
  } evT;

  evT          sbq[$];
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int dWait = 0;
  int cycle = 0;
  int nCmp  = 0;
  int nBad  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: actual %08h expected %08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [16:0] low);
    return {op, rs, rt, low};
  endfunction

  function automatic logic [16:0] im(input logic [15:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic [16:0] sh(input logic [4:0] s);
    return {s, 12'h000};
  endfunction

  // Place an instruction and expect its fetch `gap` cycles after the previous
  // fetch (0 = first after reset) with `flg` left by the previous EXEC.
  task automatic ins(input logic [31:0] a, input logic [31:0] w, input int gap,
                     input logic [3:0] flg);
    evT e;
    imem[a[9:2]] = w;
    e.isData = 1'b0; e.addr = a; e.we = 1'b0; e.data = '0; e.gap = gap; e.flg = flg;
    sbq.push_back(e);
  endtask

  task automatic dat(input logic [31:0] a, input bit we, input logic [31:0] d);
    evT e;
    e.isData = 1'b1; e.addr = a; e.we = we; e.data = d; e.gap = 0; e.flg = '0;
    sbq.push_back(e);
  endtask

  // Memory responders: decide ready just after each edge for the next one.
  initial begin
    int dCnt;
    dCnt = 0;
    imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_ready = imem_req;
      imem_rdata = imem_req ? imem[imem_addr[9:2]] : '0;
      if (!dmem_req) begin
        dCnt = 0;
        dmem_ready = 1'b0;
      end else if (dCnt >= dWait) begin
        dCnt = 0;
        dmem_ready = 1'b1;
        if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
        else         dmem_rdata = dmem[dmem_addr[9:2]];
      end else begin
        dCnt++;
        dmem_ready = 1'b0;
      end
    end
  end

  // Monitor: consumes the scoreboard at every handshake the DUT presents.
  initial begin
    evT e;
    int lastFetch;
    bit haveLast, held;
    logic [31:0] hAddr, hData;
    logic hWe;
    haveLast = 0; held = 0; lastFetch = 0; hAddr = '0; hData = '0; hWe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        haveLast = 0;
        held = 0;
      end else begin
        if (imem_req && imem_ready) begin
          if (sbq.size() == 0) check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
          else begin
            e = sbq.pop_front();
            check("fetch_kind", {31'b0, e.isData}, 32'd0);
            check("imem_addr", imem_addr, e.addr);
            check("pc", pc, e.addr);
            check("flags", {28'b0, flags}, {28'b0, e.flg});
            if (e.gap != 0 && haveLast) check("cpi", cycle - lastFetch, e.gap);
          end
          lastFetch = cycle;
          haveLast = 1;
        end
        if (dmem_req && held) begin
          check("dmem_addr_hold", dmem_addr, hAddr);
          check("dmem_wdata_hold", dmem_wdata, hData);
          check("dmem_we_hold", {31'b0, dmem_we}, {31'b0, hWe});
        end
        if (dmem_req && dmem_ready) begin
          if (sbq.size() == 0) check("unexpected_dmem", dmem_addr, 32'hFFFF_FFFF);
          else begin
            e = sbq.pop_front();
            check("dmem_kind", {31'b0, e.isData}, 32'd1);
            check("dmem_addr", dmem_addr, e.addr);
            check("dmem_we", {31'b0, dmem_we}, {31'b0, e.we});
            if (e.we) check("dmem_wdata", dmem_wdata, e.data);
          end
        end
        if (halted) check("imem_req_halted", {31'b0, imem_req}, 32'd0);
        held  = dmem_req && !dmem_ready;
        hAddr = dmem_addr; hData = dmem_wdata; hWe = dmem_we;
      end
    end
  end

  task automatic waitHalt(input string name);
    for (int i = 0; i < 3000 && !halted; i++) @(posedge clk);
    #1 check(name, {31'b0, halted}, 32'd1);
  endtask

  task automatic resetChecks(input string tag);
    check({tag, "_pc"}, pc, 32'h100);
    check({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_dmem_req"}, {31'b0, dmem_req}, 32'd0);
    check({tag, "_dmem_we"}, {31'b0, dmem_we}, 32'd0);
    check({tag, "_halted"}, {31'b0, halted}, 32'd0);
    check({tag, "_flags"}, {28'b0, flags}, 32'd0);
    check({tag, "_ir"}, {22'b0, opcode, funccode}, 32'd0);
  endtask

  initial begin
`ifdef MCDP_PERF_CNT_EN
    logic [XLEN-1:0] cyc0;
`endif
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
    dWait = 3;
    // Phase 1 program; comments give the architectural effect and resulting flags {c,z,n,v}
    ins(32'h100, enc(OP_ADDI, 3, 0, im(16'hFFFF)), 0, 4'b0000); // r3=FFFFFFFF  0010
    ins(32'h104, enc(OP_SRL,  3, 0, sh(5'd1)),     4, 4'b0010); // r3=7FFFFFFF  0000
    ins(32'h108, enc(OP_ADDI, 3, 0, im(16'h0001)), 4, 4'b0000); // r3=80000000  0011
    ins(32'h10C, enc(OP_SW,   0, 3, im(16'h0040)), 4, 4'b0011); // [40]=r3
    dat(32'h40, 1'b1, 32'h8000_0000);
    ins(32'h110, enc(OP_LW,   5, 0, im(16'h0040)), 8, 4'b0000); // r5=[40]
    dat(32'h40, 1'b0, 32'h0);
    ins(32'h114, enc(OP_SW,   0, 5, im(16'h0044)), 8, 4'b0000); // [44]=r5
    dat(32'h44, 1'b1, 32'h8000_0000);
    ins(32'h118, enc(OP_SUB,  9, 5, im(16'h0000)), 8, 4'b0000); // r9=0-80000000  0011
    ins(32'h11C, enc(OP_SUB,  3, 5, im(16'h0000)), 4, 4'b0011); // r3=0           1100
    ins(32'h120, enc(OP_ADD,  5, 5, im(16'h0000)), 4, 4'b1100); // r5=0           1101
    ins(32'h124, enc(OP_OR,   7, 3, im(16'h0000)), 4, 4'b1101); // r7=0           0100
    ins(32'h128, enc(OP_ADDI, 6, 0, im(16'h0005)), 4, 4'b0100); // r6=5           0000
    ins(32'h12C, enc(OP_SLL,  6, 0, sh(5'd4)),     4, 4'b0000); // r6=50          0000
    ins(32'h130, enc(OP_SUB,  3, 6, im(16'h0000)), 4, 4'b0000); // r3=FFFFFFB0    0010
    ins(32'h134, enc(OP_SRA,  3, 0, sh(5'd4)),     4, 4'b0010); // r3=FFFFFFFB    0010
    ins(32'h138, enc(OP_XOR,  6, 3, im(16'h0000)), 4, 4'b0010); // r6=FFFFFFAB    0010
    ins(32'h13C, enc(OP_AND,  3, 6, im(16'h0000)), 4, 4'b0010); // r3=FFFFFFAB    0010
    ins(32'h140, enc(OP_SRL,  6, 0, sh(5'd8)),     4, 4'b0010); // r6=00FFFFFF    0000
    ins(32'h144, enc(OP_SW,   0, 3, im(16'h0048)), 4, 4'b0000);
    dat(32'h48, 1'b1, 32'hFFFF_FFAB);
    ins(32'h148, enc(OP_SW,   0, 6, im(16'h004C)), 8, 4'b0000);
    dat(32'h4C, 1'b1, 32'h00FF_FFFF);
    ins(32'h14C, enc(OP_SW,   0, 9, im(16'h0058)), 8, 4'b0000);
    dat(32'h58, 1'b1, 32'h8000_0000);
    ins(32'h150, enc(OP_BR,   0, 0, im(16'hFED0)), 8, 4'b0000); // pc -> 0x20     0100
    ins(32'h020, enc(OP_BAL,  0, 0, im(16'hFFF8)), 4, 4'b0100); // pc -> 0x18, r31=0x24
    ins(32'h018, enc(OP_SW,   0, 31, im(16'h0050)), 4, 4'b0100);
    dat(32'h50, 1'b1, 32'h0000_0024);
    ins(32'h01C, enc(OP_HALT, 0, 0, im(16'h0100)), 8, 4'b0000); // halt wins over branch

    repeat (3) @(posedge clk);
    #1 resetChecks("reset");
    @(negedge clk) rst = 1'b1;
    waitHalt("halt1_reached");
    repeat (20) @(posedge clk);
    #1;
    check("halt1_pc", pc, 32'h01C);
    check("halt1_imem_req", {31'b0, imem_req}, 32'd0);
    check("halt1_sb_drained", sbq.size(), 32'd0);
`ifdef MCDP_PERF_CNT_EN
    check("instret", instret_cnt, 32'd23);
    cyc0 = cycle_cnt;
    repeat (10) @(posedge clk);
    #1 check("cycle_cnt_frozen", cycle_cnt, cyc0);
`endif

    // Phase 2: reset during a long data-memory wait
    @(negedge clk) rst = 1'b0;
    #1 resetChecks("reset2");
    dWait = 40;
    ins(32'h100, enc(OP_LW, 5, 0, im(16'h0040)), 0, 4'b0000);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 100 && !dmem_req; i++) @(posedge clk);
    #1 check("mem_wait_started", {31'b0, dmem_req}, 32'd1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_mid_pc", pc, 32'h100);
    check("rst_mid_sb_drained", sbq.size(), 32'd0);

    // Phase 3: the load's destination must read back as zero
    dWait = 0;
    ins(32'h100, enc(OP_SW, 0, 5, im(16'h0054)), 0, 4'b0000);
    dat(32'h54, 1'b1, 32'h0);
    ins(32'h104, enc(OP_HALT, 0, 0, im(16'h0000)), 5, 4'b0000);
    @(negedge clk) rst = 1'b1;
    waitHalt("halt3_reached");
    repeat (10) @(posedge clk);
    #1;
    check("halt3_pc", pc, 32'h104);
    check("halt3_sb_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
